// File: rtl/block_judge_pkg.sv
// Shared types and constants for the falling-blocks collision judge.
package block_judge_pkg;

    localparam int unsigned LIVES_W        = 4;
    localparam int unsigned GRACE_W        = 8;
    // Idle LED image is the complement of this code (only bit 1 lit).
    localparam int unsigned DISP_IDLE_CODE = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_GRACE = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

endpackage

// File: rtl/block_judge_grace_ctr.sv
// Post-hit immunity counter: load on hit, decrement on grace ticks,
// flags the tick that reaches zero and the parity used for aim blinking.
module block_judge_grace_ctr #(
    parameter int unsigned W        = 8,
    parameter int unsigned LOAD_VAL = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_dec,
    output logic o_done_c,
    output logic o_odd_c
);

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_cnt_nxt;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_load) begin
            w_cnt_nxt = W'(LOAD_VAL);
        end else if (i_dec && (r_cnt != '0)) begin
            w_cnt_nxt = r_cnt - W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    // Parity of the value the counter holds after this edge, so the blink
    // phase lines up with the registered display.
    assign o_done_c = i_dec && (r_cnt == W'(1));
    assign o_odd_c  = w_cnt_nxt[0];

endmodule

// File: rtl/block_judge_multi.sv
// Multi-life collision judge with grace window, survival score and LED image.
// Score counter present only when BLOCK_JUDGE_SCORE_EN is defined.
module block_judge_multi
    import block_judge_pkg::*;
#(
    parameter int unsigned COLS        = 8,
    parameter int unsigned ROWS        = 8,
    parameter int unsigned LIVES       = 3,
    parameter int unsigned GRACE_TICKS = 4,
    parameter int unsigned SCORE_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    input  logic                   start,
    input  logic [ROWS*COLS-1:0]   blocks,
    input  logic [COLS-1:0]        aim,
    output logic                   gameover,
    output logic [LIVES_W-1:0]     lives,
    output logic [SCORE_W-1:0]     score,
    output logic                   hit,
    output logic [ROWS*COLS-1:0]   Disp_num
);

    localparam int unsigned N = ROWS * COLS;
    localparam logic [N-1:0] DISP_IDLE = ~N'(DISP_IDLE_CODE);

    state_e               r_state;
    state_e               w_state_nxt;
    logic [LIVES_W-1:0]   r_lives;
    logic [LIVES_W-1:0]   w_lives_nxt;
    logic                 r_hit;
    logic                 w_hit_nxt;
    logic                 r_gameover;
    logic [N-1:0]         r_disp;
    logic [N-1:0]         w_disp_nxt;
    logic [N-1:0]         w_aim_ext;
    logic                 w_coll;
    logic                 w_load;
    logic                 w_dec;
    logic                 w_done;
    logic                 w_odd;

    assign w_coll    = |(aim & blocks[COLS-1:0]);
    assign w_aim_ext = N'(aim);
    assign w_dec     = tick && (r_state == ST_GRACE);

    block_judge_grace_ctr #(
        .W        (GRACE_W),
        .LOAD_VAL (GRACE_TICKS)
    ) u_grace (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_load   (w_load),
        .i_dec    (w_dec),
        .o_done_c (w_done),
        .o_odd_c  (w_odd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_lives    <= LIVES_W'(LIVES);
            r_hit      <= 1'b0;
            r_gameover <= 1'b0;
            r_disp     <= DISP_IDLE;
        end else begin
            r_state    <= w_state_nxt;
            r_lives    <= w_lives_nxt;
            r_hit      <= w_hit_nxt;
            r_gameover <= (w_state_nxt == ST_OVER);
            r_disp     <= w_disp_nxt;
        end
    end

    // Next state, lives and hit; start outranks tick in IDLE/OVER.
    always_comb begin
        w_state_nxt = r_state;
        w_lives_nxt = r_lives;
        w_hit_nxt   = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    w_state_nxt = ST_PLAY;
                    w_lives_nxt = LIVES_W'(LIVES);
                end
            end
            ST_PLAY: begin
                if (tick && w_coll) begin
                    w_hit_nxt   = 1'b1;
                    w_lives_nxt = r_lives - LIVES_W'(1);
                    if (r_lives == LIVES_W'(1)) begin
                        w_state_nxt = ST_OVER;
                    end else begin
                        w_state_nxt = ST_GRACE;
                        w_load      = 1'b1;
                    end
                end
            end
            ST_GRACE: begin
                if (w_done) begin
                    w_state_nxt = ST_PLAY;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // LED image reflects the state being entered; aim blinks during grace.
    always_comb begin
        w_disp_nxt = DISP_IDLE;
        case (w_state_nxt)
            ST_IDLE:  w_disp_nxt = DISP_IDLE;
            ST_PLAY:  w_disp_nxt = ~(blocks | w_aim_ext);
            ST_GRACE: w_disp_nxt = w_odd ? ~(blocks | w_aim_ext) : ~blocks;
            ST_OVER:  w_disp_nxt = '1;
            default:  w_disp_nxt = DISP_IDLE;
        endcase
    end

`ifdef BLOCK_JUDGE_SCORE_EN
    logic [SCORE_W-1:0] r_score;
    logic               w_score_clr;
    logic               w_score_inc;

    assign w_score_clr = start && ((r_state == ST_IDLE) || (r_state == ST_OVER));
    assign w_score_inc = tick && (((r_state == ST_PLAY) && !w_coll) || (r_state == ST_GRACE));

    // Survival counter, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_score <= '0;
        end else if (w_score_clr) begin
            r_score <= '0;
        end else if (w_score_inc && (r_score != '1)) begin
            r_score <= r_score + SCORE_W'(1);
        end
    end

    assign score = r_score;
`else
    assign score = '0;
`endif

    assign gameover = r_gameover;
    assign lives    = r_lives;
    assign hit      = r_hit;
    assign Disp_num = r_disp;

endmodule

// File: tb/tb_block_judge_multi.sv
// Scoreboard bench for block_judge_multi: directed game scenarios then random play.
module tb_block_judge_multi;

    localparam int unsigned COLS = 8;
    localparam int unsigned ROWS = 8;
    localparam int unsigned NB   = ROWS * COLS;
    localparam int unsigned SW   = 4;
    localparam int          L0   = 3;
    localparam int          G0   = 4;
    localparam int          SMAX = (1 << SW) - 1;

    // Model game phases (bench-local names)
    localparam int P_IDLE = 0, P_PLAY = 1, P_GRACE = 2, P_OVER = 3;

    typedef struct {
        logic          gov;
        logic [3:0]    lives;
        logic [SW-1:0] score;
        logic          hit;
        logic [NB-1:0] disp;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            tick = 1'b0;
    logic            start = 1'b0;
    logic [NB-1:0]   blocks = '0;
    logic [COLS-1:0] aim = 8'h01;
    logic            gameover;
    logic [3:0]      lives;
    logic [SW-1:0]   score;
    logic            hit;
    logic [NB-1:0]   Disp_num;

    int errors = 0;
    int checks = 0;
    exp_t q[$];

    int m_ph = P_IDLE, m_lives = L0, m_score = 0, m_gcnt = 0;

    block_judge_multi #(
        .COLS(COLS), .ROWS(ROWS), .LIVES(L0), .GRACE_TICKS(G0), .SCORE_W(SW)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start),
        .blocks(blocks), .aim(aim),
        .gameover(gameover), .lives(lives), .score(score),
        .hit(hit), .Disp_num(Disp_num)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Behavioural game model: one call per clock with that cycle's inputs.
    task automatic model(input bit r, input bit t, input bit s,
                         input logic [NB-1:0] b, input logic [COLS-1:0] a);
        exp_t e;
        bit   coll;
        bit   h;
        h    = 1'b0;
        coll = ((a & b[COLS-1:0]) != 0);
        if (r) begin
            m_ph = P_IDLE; m_lives = L0; m_score = 0; m_gcnt = 0;
        end else begin
            if (m_ph == P_IDLE || m_ph == P_OVER) begin
                if (s) begin
                    m_ph = P_PLAY; m_lives = L0; m_score = 0;
                end
            end else if (m_ph == P_PLAY) begin
                if (t && coll) begin
                    h = 1'b1;
                    m_lives = m_lives - 1;
                    if (m_lives == 0) m_ph = P_OVER;
                    else begin
                        m_ph = P_GRACE; m_gcnt = G0;
                    end
                end else if (t) begin
                    if (m_score < SMAX) m_score++;
                end
            end else begin
                if (t) begin
                    if (m_score < SMAX) m_score++;
                    m_gcnt--;
                    if (m_gcnt == 0) m_ph = P_PLAY;
                end
            end
        end
        e.gov   = (m_ph == P_OVER);
        e.lives = 4'(m_lives);
`ifdef BLOCK_JUDGE_SCORE_EN
        e.score = SW'(m_score);
`else
        e.score = '0;
`endif
        e.hit = h;
        case (m_ph)
            P_IDLE:  e.disp = ~NB'(2);
            P_OVER:  e.disp = '1;
            P_PLAY:  e.disp = ~(b | NB'(a));
            default: e.disp = (m_gcnt % 2 == 1) ? ~(b | NB'(a)) : ~b;
        endcase
        q.push_back(e);
    endtask

    task automatic step(input bit r, input bit t, input bit s,
                        input logic [7:0] bottom, input logic [7:0] a);
        logic [NB-1:0] b;
        b = {$urandom, $urandom};
        b[COLS-1:0] = bottom;
        @(negedge clk);
        rst = r; tick = t; start = s; blocks = b; aim = a;
        model(r, t, s, b, a);
    endtask

    // n ticks, each followed by one quiet cycle
    task automatic ticks(input int n, input logic [7:0] bottom, input logic [7:0] a);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1, 1'b0, bottom, a);
            step(1'b0, 1'b0, 1'b0, bottom, a);
        end
    endtask

    // Monitor: outputs are valid every cycle, compare against scoreboard head.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("gameover", 64'(gameover), 64'(e.gov));
            chk("lives",    64'(lives),    64'(e.lives));
            chk("score",    64'(score),    64'(e.score));
            chk("hit",      64'(hit),      64'(e.hit));
            chk("disp",     64'(Disp_num), 64'(e.disp));
        end
    end

    initial begin
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h01);
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h01);
        // Idle: colliding ticks are ignored
        ticks(5, 8'h08, 8'h08);
        // Clean play
        step(1'b0, 1'b0, 1'b1, 8'h00, 8'h01);
        ticks(10, 8'h00, 8'h01);
        // Hit, then grace with colliding ticks, back to play
        ticks(1, 8'h08, 8'h08);
        ticks(4, 8'h08, 8'h08);
        // start ignored while playing
        step(1'b0, 1'b0, 1'b1, 8'h00, 8'h01);
        // Two more hits separated by grace -> game over
        ticks(1, 8'h18, 8'h08);
        ticks(4, 8'h00, 8'h02);
        ticks(1, 8'h81, 8'h01);
        ticks(3, 8'h00, 8'h01);
        // start with tick in OVER
        step(1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF);
        // Saturation
        ticks(20, 8'h00, 8'h10);
        // Reset mid-grace
        ticks(1, 8'h10, 8'h10);
        ticks(1, 8'h10, 8'h10);
        step(1'b1, 1'b1, 1'b0, 8'h10, 8'h10);
        step(1'b0, 1'b1, 1'b0, 8'h10, 8'h10);
        // Fatal hit coinciding with reset
        step(1'b0, 1'b0, 1'b1, 8'h00, 8'h01);
        for (int k = 0; k < 2; k++) begin
            ticks(1, 8'h01, 8'h01);
            ticks(4, 8'h00, 8'h02);
        end
        step(1'b1, 1'b1, 1'b0, 8'h01, 8'h01);
        // Random play
        for (int i = 0; i < 3000; i++) begin
            bit r, t, s;
            logic [7:0] a, bt;
            r  = ($urandom_range(0, 299) == 0);
            t  = ($urandom_range(0, 2) == 0);
            s  = ($urandom_range(0, 24) == 0);
            a  = 8'($urandom_range(1, 255));
            bt = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            step(r, t, s, bt, a);
        end
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h01);
        for (int w = 0; w < 10 && q.size() > 0; w++) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/block_judge_multi.md
# block_judge_multi

Parametrised collision judge for the falling-blocks game: compares the player's aim row against the bottom row of a ROWS×COLS block field on each frame tick and tracks lives, a post-hit grace window, survival score and game state. It sits between the block-field generator/shifter and the LED matrix driver and replaces the single-life 8×8 judge. All outputs are registered.

## Interface
- COLS, 8, columns per row (aim width)
- ROWS, 8, rows in the field
- LIVES, 3, lives at game start (1..15)
- GRACE_TICKS, 4, ticks of collision immunity after a non-fatal hit (1..255)
- SCORE_W, 16, score counter width
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- tick  input  1  one-cycle frame strobe; field has advanced
- start  input  1  one-cycle start/restart request
- blocks  input  ROWS*COLS  block field; bits [COLS-1:0] are the bottom row
- aim  input  COLS  player position, one or more bits set
- gameover  output  1  high in OVER state
- lives  output  4  remaining lives
- score  output  SCORE_W  ticks survived in current game
- hit  output  1  one-cycle pulse on a counted collision
- Disp_num  output  ROWS*COLS  active-low LED image

## Operation
- States: IDLE, PLAY, GRACE, OVER.
- Reset: state IDLE, gameover 0, lives LIVES, score 0, hit 0, Disp_num = ~2 (only bit 1 low).
- IDLE: tick ignored; start → PLAY, lives LIVES, score 0.
- Collision = |(aim & blocks[COLS-1:0]), sampled only on tick.
- PLAY, tick, no collision: score += 1, saturating at all-ones.
- PLAY, tick, collision: hit pulses, lives −1, score unchanged. New lives 0 → OVER; else → GRACE, grace counter = GRACE_TICKS.
- GRACE: each tick decrements counter and scores +1; collisions ignored, no hit. Counter reaching 0 on a tick → PLAY.
- OVER: gameover 1, lives 0, score frozen; start → PLAY with lives LIVES, score 0, gameover 0.
- start in PLAY or GRACE ignored.
- Display (every cycle): OVER → all ones; IDLE → ~2; PLAY → ~{blocks[upper], blocks[COLS-1:0] | aim}; GRACE → same but aim merged only when grace counter is odd (blink).

## Timing
- All outputs update on the clk edge after the input cycle: 1-cycle latency from tick/start.
- hit high exactly one cycle, same edge as lives decrement.
- start and tick same cycle in IDLE/OVER: start wins, tick discarded.
- rst overrides all inputs, including mid-GRACE and the edge of a fatal hit.
- Disp_num follows blocks/aim with 1-cycle latency even without tick.

## Configuration
- BLOCK_JUDGE_SCORE_EN defined: score counter as above.
- Undefined: no score register; score output constant 0; all other behaviour unchanged.

## Structure
- Package block_judge_pkg: state enum, LIVES_W = 4, reset display constant.
- One sub-module natural: block_judge_grace_ctr (load, tick-decrement, done flag, odd bit for blink).

## Test plan
- Reset, no start, 5 ticks with collision → state IDLE, lives 3, hit never high, Disp_num = ~2.
- start, 10 ticks with aim=0x01, bottom row 0x00 → score 10, lives 3, gameover 0.
- Collision on tick (aim 0x08, bottom 0x08) → hit 1 cycle, lives 2, GRACE; 3 more colliding ticks → no hit; 4th tick → PLAY.
- Three separated collisions → lives 0, gameover 1, Disp_num all ones, further ticks leave score frozen.
- In OVER, start and tick same cycle → PLAY, lives 3, score 0, gameover 0 next cycle.
- SCORE_W=4, 20 clean ticks → score saturates at 15; with macro undefined → score stays 0.
